mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Sits between the instruction cache, the data cache and the single-ported RAM.
- Arbitrates every cache fill, write-back and halt flush onto the one memory port.
- Grants are registered, and the data cache has priority.
- A data-cache grant is locked for a whole block burst, so fill and write-back beats are never interleaved with instruction fetches.

## Interface
- `WORDS_PER_BLK`, default 2: data-cache beats per block burst; sets the grant lock length.
- `STARVE_LIMIT`, default 4: consecutive data-cache grants tolerated while an icache request waits (used only with `ARB_STARVE_EN`).
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `iload` out 32: read data to the icache.
- `iwait` out 1: low only for the cycle the icache access completes.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in 32: dcache word address.
- `dstore` in 32: write data from the dcache.
- `dload` out 32: read data to the dcache.
- `dwait` out 1: low only for the cycle the dcache access completes.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: `ramstate_t`, one of FREE, BUSY, ACCESS, ERROR; ACCESS means the access completes this cycle.

## Operation
- **States:** IDLE, IGRANT, DGRANT.
- **IDLE:**
  - No RAM enables are driven.
  - If `dREN|dWEN`, go to DGRANT; else if `iREN`, go to IGRANT.
  - With `ARB_STARVE_EN` and `starve_cnt==STARVE_LIMIT`, an `iREN` request wins instead.
- **IGRANT:**
  - `ramREN=1`, `ramaddr=iaddr`.
  - On `ramstate==ACCESS`: `iwait=0` and `iload=ramload` for that cycle, then go to IDLE.
  - If `iREN` drops before completion, go to IDLE; no RAM enable is driven in that cycle.
- **DGRANT:**
  - `ramWEN=dWEN`, `ramREN=dREN&~dWEN`, `ramaddr=daddr`, `ramstore=dstore`.
  - If both `dREN` and `dWEN` are asserted, the request is a write.
  - Each ACCESS pulses `dwait=0` (and `dload=ramload` for reads) and increments `beat_cnt`.
  - When `beat_cnt` reaches `WORDS_PER_BLK-1` and ACCESS occurs, go to IDLE and clear `beat_cnt`.
  - If `dREN` and `dWEN` both drop, go to IDLE next cycle and clear `beat_cnt`. This covers single-word halt flushes and hit-counter writes.
- **ramstate BUSY, FREE or ERROR:** the access is not complete. The wait signal stays high, `beat_cnt` is unchanged and the state is held.
- **Non-granted side:** its wait signal is always 1 and its load output is 0.
- **Counter widths:**
  - `beat_cnt` is `$clog2(WORDS_PER_BLK)`+1 bits.
  - `starve_cnt` is `$clog2(STARVE_LIMIT)`+1 bits and saturates at `STARVE_LIMIT`.

## Timing
- **Reset values:** state IDLE; counters 0; `ramREN`/`ramWEN` 0; `ramaddr`/`ramstore`/`iload`/`dload` 0; `iwait`/`dwait` 1.
- **Arbitration latency:** one cycle. A request seen in IDLE at edge N drives the RAM from cycle N+1.
- **Minimum access time:** 2 cycles per single access when the RAM returns ACCESS immediately. A 2-beat burst takes 3 cycles.
- **Back-to-back requests:** after a grant ends, the arbiter always passes through IDLE for one cycle. This gives a re-arbitration point between bursts.
- **Simultaneous `iREN` and dcache request in IDLE:** dcache wins, unless the starvation guard fires.
- **Reset mid-burst:** at the next edge the arbiter is in IDLE with enables low. The partial burst is abandoned, and the caches are also reset.
- **Output logic:** all outputs are combinational from the registered state plus the current inputs. There are no combinational paths from `ramstate` to the state register beyond the next-state logic.

## Configuration
- **With `ARB_STARVE_EN` defined:**
  - `starve_cnt` increments on each DGRANT entry while `iREN` is high.
  - It clears on IGRANT entry or when `iREN` is low in IDLE.
  - At `STARVE_LIMIT`, the next IDLE grants IGRANT even if the dcache is requesting.
- **Without `ARB_STARVE_EN`:** strict dcache priority. `starve_cnt` and `STARVE_LIMIT` logic are not compiled in.

## Structure
- **`cpu_types_pkg`:** `ramstate_t`, `word_t`, and a new `arb_state_t` enum (IDLE=2'b00, IGRANT=2'b01, DGRANT=2'b10).
- **Sub-module:** `arb_starve_ctr`, containing the saturating counter and its compare. It is instantiated only under `ARB_STARVE_EN`.
- **Top-level:** the FSM, `beat_cnt` and the output muxing stay in `mem_arbiter`.

## Test plan
- **Single icache read:** `iREN=1`, `iaddr=0x40`, RAM ACCESS on the 2nd grant cycle -> `ramREN=1`, `ramaddr=0x40`, one-cycle `iwait=0` with `iload=ramload`, then IDLE.
- **Simultaneous requests:** `iREN` and `dREN` asserted together -> DGRANT first. `iwait` stays 1 until the dcache burst of 2 ACCESS beats ends, then IGRANT.
- **Write-back burst with BUSY gaps:** `dWEN`, `daddr` 0x100 then 0x104, `ramstate` BUSY,ACCESS,BUSY,ACCESS -> exactly 2 `dwait=0` pulses. The icache is never granted mid-burst.
- **Early request drop:** `dREN` drops after 1 beat -> IDLE next cycle, `beat_cnt=0`. A following `iREN` is granted on the next cycle.
- **Starvation guard:** `ARB_STARVE_EN`, `STARVE_LIMIT=2`, continuous dcache requests with `iREN` held -> the icache is granted after the 2nd dcache burst. Without the macro, the icache is never granted.
- **Reset mid-burst:** assert `RST` mid-DGRANT with `ramWEN=1` -> next edge IDLE, `ramWEN=0`, `iwait=dwait=1`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state, word type and the
// memory arbiter's FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } arb_state_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of dcache grants taken while the icache waits; flags when
// the icache must be served next.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Counter clears on an icache grant or an idle icache, saturates at the limit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache traffic onto the single RAM port, dcache first,
// holding a dcache grant for a whole block. Define ARB_STARVE_EN for the icache starvation guard.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORDS_PER_BLK = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int BEAT_W = $clog2(WORDS_PER_BLK) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_BLK - 1);

    if (WORDS_PER_BLK < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("mem_arbiter: WORDS_PER_BLK and STARVE_LIMIT must be at least 1");
    end

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_next;
    logic              w_access;
    logic              w_dreq;
    logic              w_enter_d;
    logic              w_enter_i;
    logic              w_starve_fire;

    assign w_access = (ramstate_t'(ramstate) == ACCESS);
    assign w_dreq   = dREN | dWEN;

`ifdef ARB_STARVE_EN
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_starve_inc = w_enter_d & iREN;
    assign w_starve_clr = w_enter_i | ((r_state == IDLE) & ~iREN);

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .CLK        (CLK),
        .RST        (RST),
        .i_inc      (w_starve_inc),
        .i_clr      (w_starve_clr),
        .o_at_limit (w_starve_fire)
    );
`else
    assign w_starve_fire = 1'b0;
`endif

    // Next-state and beat counter logic
    always_comb begin
        w_next_state = r_state;
        w_beat_next  = r_beat_cnt;
        w_enter_d    = 1'b0;
        w_enter_i    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_starve_fire && iREN) begin
                    w_next_state = IGRANT;
                    w_enter_i    = 1'b1;
                end else if (w_dreq) begin
                    w_next_state = DGRANT;
                    w_enter_d    = 1'b1;
                end else if (iREN) begin
                    w_next_state = IGRANT;
                    w_enter_i    = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            IGRANT: begin
                if (!iREN || w_access) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = IGRANT;
                end
            end
            DGRANT: begin
                // A dropped request ends the grant early (halt flushes, single-word writes)
                if (!w_dreq) begin
                    w_next_state = IDLE;
                    w_beat_next  = '0;
                end else if (w_access && (r_beat_cnt == BEAT_LAST)) begin
                    w_next_state = IDLE;
                    w_beat_next  = '0;
                end else if (w_access) begin
                    w_beat_next  = r_beat_cnt + 1'b1;
                end else begin
                    w_next_state = DGRANT;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_beat_next  = '0;
            end
        endcase
    end

    // State and beat counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_beat_cnt <= w_beat_next;
        end
    end

    // RAM port and cache response muxing for the granted side
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = WORD_ZERO;
        ramstore = WORD_ZERO;
        iload    = WORD_ZERO;
        dload    = WORD_ZERO;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            IGRANT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (w_access) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end else begin
                        iwait = 1'b1;
                    end
                end else begin
                    ramREN = 1'b0;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_dreq && w_access) begin
                    dwait = 1'b0;
                    dload = (dREN & ~dWEN) ? ramload : WORD_ZERO;
                end else begin
                    dwait = 1'b1;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: completions are matched against a scoreboard
// of expected (side, data) pairs queued as each RAM ACCESS is driven.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_err = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    int mark;
    logic [32:0] sb_q[$];

    mem_arbiter #(
        .WORDS_PER_BLK (2),
        .STARVE_LIMIT  (2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    task automatic expect_done(input logic side, input logic [31:0] data);
        sb_q.push_back({side, data});
    endtask

    task automatic pop_check(input logic side, input logic [31:0] obs);
        logic [32:0] e;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_done: observed side %0d data %h expected no completion", side, obs);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("done_side", {31'd0, side}, {31'd0, e[32]});
            chk(side ? "dload" : "iload", obs, e[31:0]);
        end
    endtask

    // Scoreboard monitor: every wait-low pulse must match the next expected completion
    always @(negedge CLK) begin
        if (iwait === 1'b0) begin
            i_pulses++;
            pop_check(1'b0, iload);
        end
        if (dwait === 1'b0) begin
            d_pulses++;
            pop_check(1'b1, dload);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        tick(); tick();
        @(negedge CLK);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        tick();
        RST = 1'b0;

        // Single icache read, ACCESS on the second grant cycle
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        chk("ird_idle_ramREN", {31'd0, ramREN}, 32'd0);
        tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        @(negedge CLK);
        chk("ird_ramREN", {31'd0, ramREN}, 32'd1);
        chk("ird_ramaddr", ramaddr, 32'h40);
        chk("ird_iwait_busy", {31'd0, iwait}, 32'd1);
        tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hCAFE_0040);
        expect_done(1'b0, 32'hCAFE_0040);
        @(negedge CLK);
        chk("ird_ramREN_acc", {31'd0, ramREN}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        chk("ird_after_ramREN", {31'd0, ramREN}, 32'd0);
        tick();

        // Simultaneous icache and dcache read: dcache burst first
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        chk("sim_idle_ramREN", {31'd0, ramREN}, 32'd0);
        tick();
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, ACCESS, 32'h1111_1111);
        expect_done(1'b1, 32'h1111_1111);
        @(negedge CLK);
        chk("sim_d0_ramaddr", ramaddr, 32'h200);
        chk("sim_d0_ramREN", {31'd0, ramREN}, 32'd1);
        chk("sim_d0_iwait", {31'd0, iwait}, 32'd1);
        tick();
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h204, 32'h0, ACCESS, 32'h2222_2222);
        expect_done(1'b1, 32'h2222_2222);
        @(negedge CLK);
        chk("sim_d1_ramaddr", ramaddr, 32'h204);
        chk("sim_d1_iwait", {31'd0, iwait}, 32'd1);
        tick();
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        chk("sim_gap_ramREN", {31'd0, ramREN}, 32'd0);
        chk("sim_gap_iwait", {31'd0, iwait}, 32'd1);
        tick();
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h3333_3333);
        expect_done(1'b0, 32'h3333_3333);
        @(negedge CLK);
        chk("sim_i_ramaddr", ramaddr, 32'h80);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        tick();

        // Write-back burst (dREN and dWEN both high) with BUSY gaps, icache waiting
        mark = d_pulses;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hA0, FREE, 32'h0);
        tick();
        drive(1'b1, 32'h88, 1'b1, 1'b1, 32'h100, 32'hA0, BUSY, 32'hDEAD_0000);
        @(negedge CLK);
        chk("wb_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("wb_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wb_ramaddr0", ramaddr, 32'h100);
        chk("wb_ramstore0", ramstore, 32'hA0);
        chk("wb_dwait_busy", {31'd0, dwait}, 32'd1);
        tick();
        drive(1'b1, 32'h88, 1'b1, 1'b1, 32'h100, 32'hA0, ACCESS, 32'hDEAD_0001);
        expect_done(1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h88, 1'b1, 1'b1, 32'h104, 32'hA4, BUSY, 32'hDEAD_0002);
        @(negedge CLK);
        chk("wb_ramaddr1", ramaddr, 32'h104);
        chk("wb_ramstore1", ramstore, 32'hA4);
        chk("wb_mid_iwait", {31'd0, iwait}, 32'd1);
        tick();
        drive(1'b1, 32'h88, 1'b1, 1'b1, 32'h104, 32'hA4, ACCESS, 32'hDEAD_0003);
        expect_done(1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        chk("wb_end_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("wb_dpulses", d_pulses - mark, 32'd2);
        tick();
        drive(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h4444_4444);
        expect_done(1'b0, 32'h4444_4444);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        tick();

        // Early dcache drop after one beat, then icache, then a full burst
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, FREE, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS, 32'h5555_5555);
        expect_done(1'b1, 32'h5555_5555);
        tick();
        drive(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        chk("drop_ramREN", {31'd0, ramREN}, 32'd0);
        chk("drop_dwait", {31'd0, dwait}, 32'd1);
        tick();
        @(negedge CLK);
        chk("drop_idle_ramREN", {31'd0, ramREN}, 32'd0);
        tick();
        drive(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h6666_6666);
        expect_done(1'b0, 32'h6666_6666);
        @(negedge CLK);
        chk("drop_i_ramaddr", ramaddr, 32'hC0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, FREE, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, ACCESS, 32'h7777_0000);
        expect_done(1'b1, 32'h7777_0000);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h404, 32'h0, ACCESS, 32'h7777_0004);
        expect_done(1'b1, 32'h7777_0004);
        @(negedge CLK);
        chk("drop_beat_reset", {31'd0, ramREN}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        tick();

        // Continuous dcache traffic with icache held, RAM always ACCESS
        mark = i_pulses;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 32'hE0, 1'b1, 1'b0, 32'h600, 32'h0, ACCESS, 32'h7000_0000 + 32'(k));
`ifdef ARB_STARVE_EN
            if (k == 1 || k == 2 || k == 4 || k == 5) expect_done(1'b1, 32'h7000_0000 + 32'(k));
            else if (k == 7) expect_done(1'b0, 32'h7000_0000 + 32'(k));
`else
            if ((k % 3) != 0) expect_done(1'b1, 32'h7000_0000 + 32'(k));
`endif
            tick();
        end
`ifdef ARB_STARVE_EN
        chk("starve_igrants", i_pulses - mark, 32'd1);
`else
        chk("starve_igrants", i_pulses - mark, 32'd0);
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        tick(); tick();

        // Reset in the middle of a write burst
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 32'h5A, FREE, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 32'h5A, BUSY, 32'h0);
        @(negedge CLK);
        chk("rstmid_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmid_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rstmid_iwait", {31'd0, iwait}, 32'd1);
        chk("rstmid_dwait", {31'd0, dwait}, 32'd1);
        chk("rstmid_ramaddr", ramaddr, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        tick(); tick();

        chk("sb_leftover", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
